// File: rtl/fsm_input_decoder.sv
// Observes the sequence FSM's state output and decodes which input symbol(s) explain each step.
// Latency: outputs registered, visible the cycle after sample_en. Backpressure: none, every sample is consumed.
module fsm_input_decoder #(
    parameter int unsigned ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sample_en,
    input  logic [2:0]           state_in,
    input  logic                 resync,
    input  logic                 err_clr,
    output logic                 sym_valid,
    output logic [3:0]           sym_mask,
    output logic [1:0]           sym,
    output logic                 sym_unique,
    output logic                 err_pulse,
    output logic                 err_flag,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    typedef enum logic {
        CTRL_EMPTY,
        CTRL_TRACK
    } ctrl_e;

    typedef struct packed {
        logic [3:0] mask;
        logic [1:0] sym;
        logic       uniq;
    } dec_t;

    localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;
    localparam logic [ERR_CNT_W-1:0] CNT_ONE = ERR_CNT_W'(1);

    // Key is {prev, cur} written in octal, so 6'o12 reads as q1->q2.
    function automatic logic [3:0] trans_mask(input logic [2:0] prev, input logic [2:0] cur);
        logic [3:0] m;
        m = 4'b0000;
        case ({prev, cur})
            6'o01: m = 4'b1111;
            6'o12: m = 4'b1011;
            6'o13: m = 4'b0100;
            6'o24: m = 4'b1010;
            6'o27: m = 4'b0100;
            6'o20: m = 4'b0001;
            6'o35: m = 4'b1000;
            6'o32: m = 4'b0111;
            6'o43: m = 4'b1111;
            6'o56: m = 4'b1111;
            6'o63: m = 4'b1111;
            6'o71: m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    function automatic logic [1:0] lowest_bit(input logic [3:0] m);
        logic [1:0] idx;
        idx = 2'd0;
        if (m[0])      idx = 2'd0;
        else if (m[1]) idx = 2'd1;
        else if (m[2]) idx = 2'd2;
        else if (m[3]) idx = 2'd3;
        return idx;
    endfunction

    function automatic logic one_hot(input logic [3:0] m);
        return (m != 4'd0) && ((m & (m - 4'd1)) == 4'd0);
    endfunction

    ctrl_e                ctrl_q, ctrl_d;
    logic [2:0]           prev_q, prev_d;
    dec_t                 dec_q, dec_d, dec_eval;
    logic                 sym_valid_q, sym_valid_d;
    logic                 err_pulse_q, err_pulse_d;
    logic                 err_flag_q, err_flag_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [ERR_CNT_W-1:0] err_base;
    logic [3:0]           cur_mask;

    always_comb begin
        cur_mask      = trans_mask(prev_q, state_in);
        dec_eval      = '0;
        dec_eval.mask = cur_mask;
        dec_eval.sym  = lowest_bit(cur_mask);
        dec_eval.uniq = one_hot(cur_mask);
    end

    always_comb begin
        ctrl_d      = ctrl_q;
        prev_d      = prev_q;
        dec_d       = dec_q;
        sym_valid_d = 1'b0;
        err_pulse_d = 1'b0;
        err_flag_d  = err_flag_q;
        err_cnt_d   = err_cnt_q;
        // A coincident illegal step counts from the cleared value, so the error wins.
        err_base    = err_clr ? '0 : err_cnt_q;

        if (err_clr) begin
            err_flag_d = 1'b0;
            err_cnt_d  = '0;
        end

        if (sample_en && (resync || ctrl_q == CTRL_EMPTY)) begin
            ctrl_d = CTRL_TRACK;
            prev_d = state_in;
        end else if (sample_en) begin
            sym_valid_d = 1'b1;
            dec_d       = dec_eval;
            prev_d      = state_in;
            if (dec_eval.mask == 4'd0) begin
                err_pulse_d = 1'b1;
                err_flag_d  = 1'b1;
                err_cnt_d   = (err_base == CNT_MAX) ? CNT_MAX : err_base + CNT_ONE;
            end
        end else if (resync) begin
            ctrl_d = CTRL_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q      <= CTRL_EMPTY;
            prev_q      <= 3'd0;
            dec_q       <= '0;
            sym_valid_q <= 1'b0;
            err_pulse_q <= 1'b0;
            err_flag_q  <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            ctrl_q      <= ctrl_d;
            prev_q      <= prev_d;
            dec_q       <= dec_d;
            sym_valid_q <= sym_valid_d;
            err_pulse_q <= err_pulse_d;
            err_flag_q  <= err_flag_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign sym_valid  = sym_valid_q;
    assign sym_mask   = dec_q.mask;
    assign sym        = dec_q.sym;
    assign sym_unique = dec_q.uniq;
    assign err_pulse  = err_pulse_q;
    assign err_flag   = err_flag_q;
    assign err_cnt    = err_cnt_q;

endmodule
